// File: rtl/ether_tx_pkg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ether_tx_pkg_buffer
// Brief    : Two-bank ping-pong transmit packet buffer in front of the MAC.
//            The host fills one bank while the other is being sent.
// Revision : 1.0 - initial release
// ============================================================================
module ether_tx_pkg_buffer #(
  parameter int P_ADDR_W   = 9,
  parameter int P_IRQ_HOLD = 2,
  parameter int P_GAP      = 2,
  parameter int P_BUSY_TO  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_commit,
  input  logic [9:0]  i_wr_length,
  output logic        o_wr_ready,
  output logic        o_wr_err,
  output logic        o_SendIrq,
  output logic [9:0]  o_length,
  input  logic [9:0]  i_data_addr,
  output logic [15:0] o_data_send,
  input  logic        i_renew_pkg,
  output logic        o_timeout,
  output logic [1:0]  o_pkg_cnt
);

  localparam int C_DEPTH = 1 << P_ADDR_W;
  localparam int C_CNT_W = $clog2(P_BUSY_TO + P_IRQ_HOLD + P_GAP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IRQ       = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  logic [15:0]        r_mem [0:2*C_DEPTH-1];
  logic [1:0]         r_full;
  logic [9:0]         r_len [0:1];
  logic               r_fill;
  logic               r_send;
  logic [P_ADDR_W:0]  r_wptr;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic               w_irq_nxt;
  logic               w_timeout_nxt;
  logic               w_length_load;
  logic               w_release;
  logic               w_wr_fire;
  logic               w_wr_ovf;
  logic               w_commit_ok;
  logic               w_commit_bad;

  generate
    if (P_ADDR_W < 10) begin : g_addr_unused
      logic w_unused_addr;
      assign w_unused_addr = ^i_data_addr[9:P_ADDR_W];
    end
  endgenerate

  // The fill bank is free whenever fewer than two frames are pending.
  assign o_wr_ready   = ~r_full[r_fill];
  assign o_pkg_cnt    = {r_full[0] & r_full[1], r_full[0] ^ r_full[1]};
  assign w_wr_fire    = i_wr_en & o_wr_ready & ~r_wptr[P_ADDR_W];
  assign w_wr_ovf     = i_wr_en & o_wr_ready &  r_wptr[P_ADDR_W];
  assign w_commit_ok  = i_wr_commit & o_wr_ready & (i_wr_length != 10'd0);
  assign w_commit_bad = i_wr_commit & ~w_commit_ok;

  always_ff @(posedge i_clk) begin
    if (w_wr_fire) r_mem[{r_fill, r_wptr[P_ADDR_W-1:0]}] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_data_send <= 16'd0;
    else          o_data_send <= r_mem[{r_send, i_data_addr[P_ADDR_W-1:0]}];
  end

  // Commit and release always touch different banks, so both may apply at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full   <= 2'b00;
      r_len[0] <= 10'd0;
      r_len[1] <= 10'd0;
      r_fill   <= 1'b0;
      r_send   <= 1'b0;
      r_wptr   <= '0;
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= w_wr_ovf | w_commit_bad;
      if (w_wr_fire) r_wptr <= r_wptr + 1'b1;
      if (w_commit_ok) begin
        r_full[r_fill] <= 1'b1;
        r_len[r_fill]  <= i_wr_length;
        r_wptr         <= '0;
        r_fill         <= ~r_fill;
      end
      if (w_release) begin
        r_full[r_send] <= 1'b0;
        r_send         <= ~r_send;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      o_SendIrq <= 1'b0;
      o_timeout <= 1'b0;
      o_length  <= 10'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      o_SendIrq <= w_irq_nxt;
      o_timeout <= w_timeout_nxt;
      if (w_length_load) o_length <= r_len[r_send];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_irq_nxt     = o_SendIrq;
    w_timeout_nxt = 1'b0;
    w_length_load = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_send]) begin
          w_length_load = 1'b1;
          w_irq_nxt     = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IRQ;
        end
      end
      S_IRQ: begin
        if (r_cnt == C_CNT_W'(P_IRQ_HOLD - 1)) begin
          w_irq_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_BUSY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!i_renew_pkg) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == C_CNT_W'(P_BUSY_TO - 1)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_renew_pkg) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_release   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == C_CNT_W'(P_GAP - 1)) w_state_nxt = S_IDLE;
        else                              w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ether_tx_pkg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ether_tx_pkg_buffer
// Brief    : Self-checking bench for the ping-pong transmit packet buffer,
//            using a frame-FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ether_tx_pkg_buffer;

  localparam int P_ADDR_W   = 9;
  localparam int P_IRQ_HOLD = 2;
  localparam int P_GAP      = 2;
  localparam int P_BUSY_TO  = 1024;
  localparam int DEPTH      = 1 << P_ADDR_W;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = 16'd0;
  logic        i_wr_commit = 1'b0;
  logic [9:0]  i_wr_length = 10'd0;
  logic [9:0]  i_data_addr = 10'd0;
  logic        i_renew_pkg = 1'b1;
  logic        o_wr_ready, o_wr_err, o_SendIrq, o_timeout;
  logic [9:0]  o_length;
  logic [15:0] o_data_send;
  logic [1:0]  o_pkg_cnt;

  always #5 i_clk = ~i_clk;

  ether_tx_pkg_buffer #(
    .P_ADDR_W(P_ADDR_W), .P_IRQ_HOLD(P_IRQ_HOLD), .P_GAP(P_GAP), .P_BUSY_TO(P_BUSY_TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_wr_commit(i_wr_commit), .i_wr_length(i_wr_length), .o_wr_ready(o_wr_ready),
    .o_wr_err(o_wr_err), .o_SendIrq(o_SendIrq), .o_length(o_length),
    .i_data_addr(i_data_addr), .o_data_send(o_data_send), .i_renew_pkg(i_renew_pkg),
    .o_timeout(o_timeout), .o_pkg_cnt(o_pkg_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: FIFO of committed frames (max two) plus the frame being staged.
  logic [15:0] m_dat [0:1][0:DEPTH-1];
  int          m_len [0:1];
  int          m_head = 0;
  int          m_cnt = 0;
  logic [15:0] m_stage [0:DEPTH-1];
  int          m_nst = 0;
  int          last_rise = -1;
  int          last_fall = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_push(input int len);
    int slot;
    slot = (m_head + m_cnt) % 2;
    m_len[slot] = len;
    for (int k = 0; k < m_nst; k++) m_dat[slot][k] = m_stage[k];
    m_cnt++;
    m_nst = 0;
  endtask

  task automatic model_pop();
    m_head = (m_head + 1) % 2;
    m_cnt--;
  endtask

  task automatic model_reset();
    m_head = 0; m_cnt = 0; m_nst = 0; last_rise = -1;
  endtask

  task automatic write_words(input int n, input bit seq);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = seq ? 16'(k + 1) : 16'($urandom);
      i_wr_en = 1'b1; i_wr_data = w;
      tick();
      if (m_nst < DEPTH) begin
        m_stage[m_nst] = w;
        m_nst++;
      end
    end
    i_wr_en = 1'b0;
  endtask

  task automatic host_commit(input int len);
    bit ok;
    ok = (m_cnt < 2) && (len != 0);
    i_wr_commit = 1'b1; i_wr_length = 10'(len);
    tick();
    i_wr_commit = 1'b0;
    if (ok) model_push(len);
    checks++;
    if (o_wr_err !== (ok ? 1'b0 : 1'b1))
      begin failures++; $display("FAIL commit_err: len=%0d o_wr_err=%b required %b", len, o_wr_err, !ok); end
    checks++;
    if (o_pkg_cnt !== 2'(m_cnt))
      begin failures++; $display("FAIL commit_cnt: o_pkg_cnt=%0d required %0d", o_pkg_cnt, m_cnt); end
  endtask

  task automatic mac_catch_irq();
    int t, hi;
    t = 0;
    while (o_SendIrq !== 1'b1 && t < 3000) begin tick(); t++; end
    checks++;
    if (o_SendIrq !== 1'b1 || m_cnt == 0) begin
      failures++;
      $display("FAIL irq_rise: o_SendIrq=%b pending=%0d, required a rise with a pending frame", o_SendIrq, m_cnt);
      return;
    end
    if (last_rise >= 0) begin
      checks++;
      if (cyc - last_rise < P_IRQ_HOLD + P_GAP + 2)
        begin failures++; $display("FAIL irq_spacing: %0d cycles, required >= %0d", cyc - last_rise, P_IRQ_HOLD + P_GAP + 2); end
    end
    last_rise = cyc;
    checks++;
    if (o_length !== 10'(m_len[m_head]))
      begin failures++; $display("FAIL irq_length: o_length=%0d required %0d", o_length, m_len[m_head]); end
    hi = 0;
    while (o_SendIrq === 1'b1 && hi < 20) begin tick(); hi++; end
    last_fall = cyc;
    checks++;
    if (hi != P_IRQ_HOLD)
      begin failures++; $display("FAIL irq_hold: high %0d cycles, required %0d", hi, P_IRQ_HOLD); end
  endtask

  task automatic mac_finish(input int nreads);
    int nw, a;
    if (m_cnt == 0) begin
      checks++; failures++;
      $display("FAIL mac_finish: no pending frame, required 1");
      return;
    end
    repeat ($urandom_range(15, 0)) tick();
    i_renew_pkg = 1'b0;
    nw = (m_len[m_head] + 1) / 2;
    tick();
    for (int k = 0; k < nreads; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? nw - 1 : int'($urandom_range(nw - 1, 0));
      i_data_addr = 10'(a) | (10'($urandom_range(1, 0)) << P_ADDR_W);
      tick();
      checks++;
      if (o_data_send !== m_dat[m_head][a])
        begin failures++; $display("FAIL read_data: addr=%0d o_data_send=%h required %h", a, o_data_send, m_dat[m_head][a]); end
    end
    i_renew_pkg = 1'b1;
    tick();
    tick();
    model_pop();
    checks++;
    if (o_pkg_cnt !== 2'(m_cnt) || o_timeout !== 1'b0 || o_wr_ready !== (m_cnt < 2))
      begin failures++; $display("FAIL release: cnt=%0d timeout=%b ready=%b required cnt=%0d timeout=0 ready=%b", o_pkg_cnt, o_timeout, o_wr_ready, m_cnt, m_cnt < 2); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o_wr_ready !== 1'b1 || o_SendIrq !== 1'b0 || o_length !== 10'd0 || o_data_send !== 16'd0 ||
        o_wr_err !== 1'b0 || o_timeout !== 1'b0 || o_pkg_cnt !== 2'd0)
      begin failures++; $display("FAIL %s: ready=%b irq=%b len=%0d data=%h err=%b to=%b cnt=%0d required 1 0 0 0000 0 0 0", tag, o_wr_ready, o_SendIrq, o_length, o_data_send, o_wr_err, o_timeout, o_pkg_cnt); end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_reset_outputs("reset_hold");
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_wr_ready !== 1'b1 || o_pkg_cnt !== 2'd0 || o_SendIrq !== 1'b0)
      begin failures++; $display("FAIL reset_release: ready=%b cnt=%0d irq=%b required 1 0 0", o_wr_ready, o_pkg_cnt, o_SendIrq); end
  endtask

  task automatic test_single_frame();
    write_words(30, 1'b1);
    host_commit(60);
    mac_catch_irq();
    i_data_addr = 10'd5;
    tick();
    checks++;
    if (o_data_send !== 16'h0006)
      begin failures++; $display("FAIL single_addr5: o_data_send=%h required 0006", o_data_send); end
    mac_finish(6);
  endtask

  task automatic test_ping_pong();
    int bad;
    write_words(32, 1'b0);
    host_commit(64);
    mac_catch_irq();
    write_words(50, 1'b0);
    host_commit(100);
    checks++;
    if (o_wr_ready !== 1'b0 || o_pkg_cnt !== 2'd2)
      begin failures++; $display("FAIL pp_full: ready=%b cnt=%0d required 0 2", o_wr_ready, o_pkg_cnt); end
    host_commit(20);
    bad = 0;
    i_wr_en = 1'b1; i_wr_data = 16'hBAD0;
    repeat (3) begin tick(); if (o_wr_err !== 1'b0) bad++; end
    i_wr_en = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL pp_write_ignored: err seen %0d times, required 0", bad); end
    mac_finish(6);
    mac_catch_irq();
    mac_finish(6);
  endtask

  task automatic test_overflow();
    write_words(DEPTH, 1'b0);
    checks++;
    if (o_wr_err !== 1'b0) begin failures++; $display("FAIL ovf_last_ok: o_wr_err=%b required 0", o_wr_err); end
    i_wr_en = 1'b1; i_wr_data = 16'hDEAD;
    tick();
    i_wr_en = 1'b0;
    checks++;
    if (o_wr_err !== 1'b1) begin failures++; $display("FAIL ovf_err: o_wr_err=%b required 1", o_wr_err); end
    tick();
    checks++;
    if (o_wr_err !== 1'b0) begin failures++; $display("FAIL ovf_pulse: o_wr_err=%b required 0", o_wr_err); end
    host_commit(0);
    host_commit(1023);
    mac_catch_irq();
    mac_finish(8);
  endtask

  task automatic test_timeout();
    int t;
    write_words(10, 1'b0);
    host_commit(20);
    mac_catch_irq();
    write_words(8, 1'b0);
    host_commit(15);
    t = 0;
    while (o_timeout !== 1'b1 && t < 1200) begin tick(); t++; end
    checks++;
    if (o_timeout !== 1'b1 || cyc - last_fall != P_BUSY_TO)
      begin failures++; $display("FAIL timeout_time: o_timeout=%b after %0d cycles, required 1 after %0d", o_timeout, cyc - last_fall, P_BUSY_TO); end
    tick();
    model_pop();
    checks++;
    if (o_timeout !== 1'b0 || o_pkg_cnt !== 2'(m_cnt))
      begin failures++; $display("FAIL timeout_release: to=%b cnt=%0d required 0 %0d", o_timeout, o_pkg_cnt, m_cnt); end
    mac_catch_irq();
    mac_finish(5);
  endtask

  task automatic test_simultaneous();
    int bad;
    write_words(6, 1'b0);
    host_commit(12);
    mac_catch_irq();
    write_words(9, 1'b0);
    i_renew_pkg = 1'b0;
    tick(); tick();
    i_renew_pkg = 1'b1;
    tick();
    i_wr_commit = 1'b1; i_wr_length = 10'd18;
    tick();
    i_wr_commit = 1'b0;
    model_pop();
    model_push(18);
    checks++;
    if (o_pkg_cnt !== 2'd1 || o_wr_ready !== 1'b1 || o_wr_err !== 1'b0)
      begin failures++; $display("FAIL simul_state: cnt=%0d ready=%b err=%b required 1 1 0", o_pkg_cnt, o_wr_ready, o_wr_err); end
    bad = 0;
    for (int k = 0; k < P_GAP; k++) begin tick(); if (o_SendIrq !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL simul_gap: irq high %0d gap cycles, required 0", bad); end
    mac_catch_irq();
    mac_finish(6);
  endtask

  task automatic test_reset_mid();
    write_words(4, 1'b0);
    host_commit(8);
    mac_catch_irq();
    i_renew_pkg = 1'b0;
    tick(); tick();
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    tick();
    i_rst_n = 1'b1;
    i_renew_pkg = 1'b1;
    tick();
    write_words(7, 1'b0);
    host_commit(13);
    mac_catch_irq();
    mac_finish(5);
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 6; f++) begin
      len = int'($urandom_range(300, 1));
      write_words((len + 1) / 2, 1'b0);
      host_commit(len);
      mac_catch_irq();
      mac_finish(4);
      repeat ($urandom_range(5, 0)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ping_pong();
    test_overflow();
    test_timeout();
    test_simultaneous();
    test_random_frames();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
